// File: rtl/verin_avalon2_pio_pkg.sv
// Shared constants and types for the verin Avalon-MM PIO/PWM output port.
package verin_avalon2_pio_pkg;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned BUS_W  = 32;

  localparam logic [ADDR_W-1:0] ADDR_DATA     = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_MODE     = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_SET      = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_CLEAR    = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_CTRL     = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_PRESCALE = 3'd5;
  localparam logic [ADDR_W-1:0] ADDR_PERIOD   = 3'd6;
  localparam logic [ADDR_W-1:0] ADDR_DUTY     = 3'd7;

  localparam int unsigned CTRL_EN_BIT = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BUS_W-1:0]  data;
  } bus_wr_t;

endpackage

// File: rtl/verin_avalon2_pwm_gen.sv
// Shared PWM generator: prescaler, period counter and duty comparator.
module verin_avalon2_pwm_gen #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned PRE_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             restart,
  input  logic [PRE_W-1:0] prescale,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] duty,
  output logic             pwm
);

  logic [PRE_W-1:0] pre_cnt;
  logic [CNT_W-1:0] per_cnt;
  logic             tick;

  assign tick = en && (pre_cnt == prescale);

  // Counters sit at zero while disabled so enabling always starts a fresh period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= '0;
      per_cnt <= '0;
    end else if (!en || restart) begin
      pre_cnt <= '0;
      per_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
      per_cnt <= (per_cnt == period) ? '0 : per_cnt + CNT_W'(1);
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  assign pwm = en && (per_cnt < duty);

endmodule

// File: rtl/verin_avalon2_pio_pwm.sv
// Avalon-MM multi-channel output port with atomic set/clear and a shared PWM source.
module verin_avalon2_pio_pwm
  import verin_avalon2_pio_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned PRE_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  bus_wr_t          wr_req;
  logic             wr;
  logic             restart;
  logic             pwm;

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] mode_q;
  logic             en_q;
  logic [PRE_W-1:0] prescale_q;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] duty_q;

  assign wr_req = '{addr: address, data: writedata};
  assign wr     = chipselect && !write_n;

  // Timebase changes and an enable rising edge restart the period cleanly.
  assign restart = wr && ((wr_req.addr == ADDR_PRESCALE) ||
                          (wr_req.addr == ADDR_PERIOD) ||
                          ((wr_req.addr == ADDR_CTRL) && wr_req.data[CTRL_EN_BIT] && !en_q));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q     <= '0;
      mode_q     <= '0;
      en_q       <= 1'b0;
      prescale_q <= '0;
      period_q   <= '0;
      duty_q     <= '0;
    end else if (wr) begin
      case (wr_req.addr)
        ADDR_DATA:     data_q     <= wr_req.data[WIDTH-1:0];
        ADDR_MODE:     mode_q     <= wr_req.data[WIDTH-1:0];
        ADDR_SET:      data_q     <= data_q | wr_req.data[WIDTH-1:0];
        ADDR_CLEAR:    data_q     <= data_q & ~wr_req.data[WIDTH-1:0];
        ADDR_CTRL:     en_q       <= wr_req.data[CTRL_EN_BIT];
        ADDR_PRESCALE: prescale_q <= wr_req.data[PRE_W-1:0];
        ADDR_PERIOD:   period_q   <= wr_req.data[CNT_W-1:0];
        ADDR_DUTY:     duty_q     <= wr_req.data[CNT_W-1:0];
        default: ;
      endcase
    end
  end

  verin_avalon2_pwm_gen #(
    .CNT_W (CNT_W),
    .PRE_W (PRE_W)
  ) u_pwm (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en_q),
    .restart  (restart),
    .prescale (prescale_q),
    .period   (period_q),
    .duty     (duty_q),
    .pwm      (pwm)
  );

  // PWM-mode channels are gated by their DATA bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_port <= '0;
    end else begin
      out_port <= data_q & (~mode_q | {WIDTH{pwm}});
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:     readdata = 32'(data_q);
      ADDR_MODE:     readdata = 32'(mode_q);
      ADDR_CTRL:     readdata = 32'(en_q);
      ADDR_PRESCALE: readdata = 32'(prescale_q);
      ADDR_PERIOD:   readdata = 32'(period_q);
      ADDR_DUTY:     readdata = 32'(duty_q);
      default:       readdata = '0;
    endcase
  end

endmodule
